// File: rtl/matrix_readout.sv
// matrix_readout: snapshots the DIM x DIM hit-count matrix on start and
// streams the entries out in row-major order over a valid/ready interface.
// Optional build macro: MATRIX_READOUT_PEAK_DETECT_EN enables running-maximum
// peak tracking on peak_index/peak_value (tied to zero when undefined).
`timescale 1ns/1ps
module matrix_readout #(
  parameter int DIM     = 3,
  parameter int COUNT_W = 9,
  parameter int IDX_W   = $clog2(DIM*DIM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DIM*DIM*COUNT_W-1:0] matrix_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COUNT_W-1:0]         out_data,
  output logic [IDX_W-1:0]           out_index,
  output logic [$clog2(DIM)-1:0]     out_x,
  output logic [$clog2(DIM)-1:0]     out_y,
  output logic                       out_last,
  output logic                       done,
  output logic [IDX_W-1:0]           peak_index,
  output logic [COUNT_W-1:0]         peak_value
);

  localparam int N    = DIM * DIM;
  localparam int XY_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_k;
  logic [IDX_W-1:0]       w_k_nxt;
  logic [N*COUNT_W-1:0]   r_snap;
  logic                   w_accept;
  logic                   w_hs;

  logic                   r_busy;
  logic                   r_out_valid;
  logic [COUNT_W-1:0]     r_out_data;
  logic [IDX_W-1:0]       r_out_index;
  logic [XY_W-1:0]        r_out_x;
  logic [XY_W-1:0]        r_out_y;
  logic                   r_out_last;
  logic                   r_done;

  // Select one counter entry out of the packed snapshot.
  function automatic logic [COUNT_W-1:0] f_entry(input logic [N*COUNT_W-1:0] arr,
                                                 input logic [IDX_W-1:0]     k);
    f_entry = arr[k*COUNT_W +: COUNT_W];
  endfunction

  // Row coordinate of entry k.
  function automatic logic [XY_W-1:0] f_row(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] q;
    q = k / IDX_W'(DIM);
    return q[XY_W-1:0];
  endfunction

  // Column coordinate of entry k.
  function automatic logic [XY_W-1:0] f_col(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] q;
    q = k % IDX_W'(DIM);
    return q[XY_W-1:0];
  endfunction

  // out_valid is only ever high in STREAM, so this is the entry handshake.
  assign w_hs = r_out_valid & out_ready;

  // Next-state and next-index decode.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_STREAM;
          w_k_nxt     = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (w_hs) begin
          if (r_k == LAST_K) begin
            w_state_nxt = S_DONE;
          end else begin
            w_k_nxt = r_k + IDX_W'(1);
          end
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, index and snapshot registers; snapshot only loads on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_snap  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_accept) begin
        r_snap <= matrix_in;
      end
    end
  end

  // Output registers loaded from the next state so outputs line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE);
      r_out_valid <= (w_state_nxt == S_STREAM);
      r_done      <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_STREAM) begin
        // On the accept edge the snapshot is loading, so entry 0 comes from the same source.
        r_out_data  <= w_accept ? matrix_in[COUNT_W-1:0] : f_entry(r_snap, w_k_nxt);
        r_out_index <= w_k_nxt;
        r_out_x     <= f_row(w_k_nxt);
        r_out_y     <= f_col(w_k_nxt);
        r_out_last  <= (w_k_nxt == LAST_K);
      end else begin
        r_out_data  <= '0;
        r_out_index <= '0;
        r_out_x     <= '0;
        r_out_y     <= '0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_last  = r_out_last;
  assign done      = r_done;

`ifdef MATRIX_READOUT_PEAK_DETECT_EN
  logic [COUNT_W-1:0] r_run_val;
  logic [IDX_W-1:0]   r_run_idx;
  logic [COUNT_W-1:0] r_peak_val;
  logic [IDX_W-1:0]   r_peak_idx;
  logic [COUNT_W-1:0] w_cand_val;
  logic [IDX_W-1:0]   w_cand_idx;

  // Strictly-greater update keeps the lowest index on ties.
  always_comb begin
    w_cand_val = r_run_val;
    w_cand_idx = r_run_idx;
    if (w_hs && (r_out_data > r_run_val)) begin
      w_cand_val = r_out_data;
      w_cand_idx = r_out_index;
    end else begin
      w_cand_val = r_run_val;
      w_cand_idx = r_run_idx;
    end
  end

  // Running maximum; published together with the DONE cycle, cleared on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_val  <= '0;
      r_run_idx  <= '0;
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else if (w_accept) begin
      r_run_val  <= '0;
      r_run_idx  <= '0;
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else if (w_hs) begin
      r_run_val <= w_cand_val;
      r_run_idx <= w_cand_idx;
      if (r_out_last) begin
        r_peak_val <= w_cand_val;
        r_peak_idx <= w_cand_idx;
      end
    end
  end

  assign peak_index = r_peak_idx;
  assign peak_value = r_peak_val;
`else
  assign peak_index = '0;
  assign peak_value = '0;
`endif

endmodule
